// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell plus a carry
// flip-flop, LSB first. Each result takes WIDTH cycles and ends with a one-cycle
// done pulse.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered two's-complement
// overflow output.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_bit;
    logic             s_bit;
    logic             cy_nxt;
    logic [WIDTH-1:0] sum_sh_nxt;

    // Full-adder cell on the current LSBs, and start acceptance in IDLE or DONE
    always_comb begin
        accept     = start && ((state == IDLE) || (state == DONE));
        last_bit   = (cnt == CW'(WIDTH - 1));
        s_bit      = a_sh[0] ^ b_sh[0] ^ cy;
        cy_nxt     = (a_sh[0] & b_sh[0]) | (a_sh[0] & cy) | (b_sh[0] & cy);
        sum_sh_nxt = {s_bit, sum_sh[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ADD : IDLE;
            ADD:     state_nxt = last_bit ? DONE : ADD;
            DONE:    state_nxt = start ? ADD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so busy/done are flops
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (state_nxt == ADD) begin
            busy_nxt = 1'b1;
        end
        if (state_nxt == DONE) begin
            done_nxt = 1'b1;
        end
    end

    // Status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // Operand/sum shift registers, carry flop and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cy     <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            cy     <= carry_in;
            cnt    <= '0;
        end else if (state == ADD) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_sh_nxt;
            cy     <= cy_nxt;
            cnt    <= cnt + CW'(1);
        end
    end

    // Result registers, updated only on the edge that processes the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else if ((state == ADD) && last_bit) begin
            sum       <= sum_sh_nxt;
            carry_out <= cy_nxt;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Overflow: carry into the MSB differs from carry out of the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if ((state == ADD) && last_bit) begin
            overflow <= cy ^ cy_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic model.
module tb_serial_adder;

    localparam int unsigned W  = 8;
    localparam int unsigned W1 = W + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         overflow;
`endif

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry_out(carry_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned sum as a (W+1)-bit integer
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return W1'(t);
    endfunction

    // Reference: signed overflow from operand and result signs
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [W-1:0] r);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ovf();
`ifdef SERIAL_ADDER_OVF_EN
        return overflow;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one operation and capture what the DUT shows; comparisons are made by callers
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                          output logic [W-1:0] s, output logic co, output logic ov,
                          output int bad, output logic dn, output logic dn_after);
        logic [W-1:0] prev_sum;
        prev_sum = sum;
        bad = 0;
        a = ia; b = ib; carry_in = icin; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
        for (int i = 0; i < int'(W); i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || sum !== prev_sum) bad++;
            tick();
        end
        s = sum; co = carry_out; ov = get_ovf();
        dn = (done === 1'b1) && (busy === 1'b0);
        tick();
        dn_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || carry_out !== 1'b0 || get_ovf() !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, carry_out, get_ovf());
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic icin);
        logic [W-1:0] s; logic co, ov, dn, dn_after; int bad;
        logic [W:0] r;
        r = ref_add(ia, ib, icin);
        run_op(ia, ib, icin, s, co, ov, bad, dn, dn_after);
        checks++;
        if (s !== r[W-1:0] || co !== r[W]) begin
            errors++;
            $display("FAIL %s_result: %h+%h+%b got sum=%h cout=%b, want sum=%h cout=%b",
                     name, ia, ib, icin, s, co, r[W-1:0], r[W]);
        end
        checks++;
        if (bad != 0 || dn !== 1'b1 || dn_after !== 1'b0) begin
            errors++;
            $display("FAIL %s_handshake: busy_window_errs=%0d done=%b done_next=%b, want 0 1 0",
                     name, bad, dn, dn_after);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ov !== ref_ovf(ia, ib, r[W-1:0])) begin
            errors++;
            $display("FAIL %s_overflow: got %b, want %b", name, ov, ref_ovf(ia, ib, r[W-1:0]));
        end
`endif
    endtask

    task automatic test_basic();
        check_op("basic", 8'h5A, 8'h25, 1'b0);
    endtask

    task automatic test_carry_chain();
        check_op("carry_ff01", 8'hFF, 8'h01, 1'b0);
        check_op("carry_ffff1", 8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_start_while_busy();
        int early_done;
        int late_done;
        a = 8'h10; b = 8'h20; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        early_done = 0;
        for (int i = 3; i < int'(W); i++) begin
            if (done !== 1'b0) early_done++;
            tick();
        end
        checks++;
        if (early_done != 0 || done !== 1'b1 || sum !== 8'h30) begin
            errors++;
            $display("FAIL busy_start_ignored: early_dones=%0d done=%b sum=%h, want 0 1 30",
                     early_done, done, sum);
        end
        late_done = 0;
        for (int i = 0; i < int'(W) + 2; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) late_done++;
        end
        checks++;
        if (late_done != 0) begin
            errors++;
            $display("FAIL busy_start_no_second: extra activity cycles=%0d, want 0", late_done);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        a = 8'h01; b = 8'h02; carry_in = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < int'(W); i++) tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h03) begin
            errors++;
            $display("FAIL b2b_first: done=%b busy=%b sum=%h, want 1 0 03", done, busy, sum);
        end
        gap = -1;
        for (int n = 1; n <= 2 * int'(W); n++) begin
            tick();
            if (done === 1'b1) begin
                gap = n;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (gap != int'(W) + 1 || sum !== 8'h03) begin
            errors++;
            $display("FAIL b2b_second: gap=%0d sum=%h, want gap=%0d sum=03", gap, sum, W + 1);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        a = 8'h33; b = 8'h44; carry_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || carry_out !== 1'b0 || get_ovf() !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, carry_out, get_ovf());
        end
        tick();
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < int'(W) + 2; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_mid_abort: stray activity cycles=%0d, want 0", stray);
        end
        check_op("after_reset", 8'h03, 8'h04, 1'b0);
    endtask

    task automatic test_overflow();
`ifdef SERIAL_ADDER_OVF_EN
        check_op("ovf_7f01", 8'h7F, 8'h01, 1'b0);
        check_op("ovf_8080", 8'h80, 8'h80, 1'b0);
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            check_op("random", W'($urandom), W'($urandom), 1'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder: one full-adder cell plus a carry flip-flop, evaluated one bit per clock, LSB first. It latches two N-bit operands and a carry-in on a start request. After N cycles it presents the N-bit sum and the carry-out with a one-cycle done pulse. It sits directly downstream of the 1-bit full-adder stage, sequencing that cell over multi-bit operands, and trades area for latency in the combinational-logic workshop datapath.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on rising clk.
- a  input  WIDTH  operand A; sampled only on an accepted start.
- b  input  WIDTH  operand B; sampled only on an accepted start.
- carry_in  input  1  initial carry; sampled only on an accepted start.
- busy  output  1  high while bits are being computed.
- done  output  1  one-cycle pulse when sum/carry_out become valid.
- sum  output  WIDTH  result, registered, held until the next completion.
- carry_out  output  1  final carry, registered, held with sum.
- overflow  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States: IDLE, ADD, DONE. Bit counter is ceil(log2(WIDTH)) bits wide.
- IDLE:
  - start=1 at an edge latches a→a_sh, b→b_sh, carry_in→cy, and clears the counter and the sum shift register. Goes to ADD.
  - start=0: stay in IDLE.
- ADD, each edge:
  - s = a_sh[0]^b_sh[0]^cy; cy ← maj(a_sh[0], b_sh[0], cy).
  - a_sh and b_sh shift right by one. s shifts into the sum shift register from the MSB side.
  - Counter increments.
  - On the edge that processes bit WIDTH-1: copy the shift register to sum and the new cy to carry_out, then go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - start=1 is accepted exactly as in IDLE and goes to ADD, giving back-to-back operation.
  - Otherwise goes to IDLE.
- start in ADD is ignored. No queuing, and the latched operands are unaffected.
- Changes on a, b or carry_in while not accepting have no effect.
- Arithmetic is unsigned modulo 2^WIDTH, with carry_out as bit WIDTH of a+b+carry_in.
- sum and carry_out change only on the completion edge. They never show partial results.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, and all internal registers 0.
- Reset mid-ADD aborts the operation. No done is produced and outputs read 0.
- Release of rst is synchronous to clk. The first edge with rst=0 may accept start.
- start accepted at edge k:
  - busy=1 from after edge k to after edge k+WIDTH.
  - done=1 and sum/carry_out valid from after edge k+WIDTH.
  - done deasserts after edge k+WIDTH+1 unless a new operation completes.
- Latency from start edge to done is WIDTH cycles. Maximum throughput is one result per WIDTH+1 cycles.
- busy and done are never high together.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds the overflow output = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, i.e. two's-complement overflow.
  - overflow is registered and updated with sum. It is 0 on reset.
- Not defined: the overflow port and its logic are absent. All other behaviour is identical.

## Test plan
- Basic add, WIDTH=8: a=8'h5A, b=8'h25, carry_in=0 → after 8 cycles, done pulses 1 cycle, sum=8'h7F, carry_out=0, busy low.
- Carry chain: a=8'hFF, b=8'h01, carry_in=0 → sum=8'h00, carry_out=1. Then a=8'hFF, b=8'hFF, carry_in=1 → sum=8'hFF, carry_out=1.
- Start while busy: start a=8'h10, b=8'h20, then pulse start with a=8'hAA, b=8'h55 at cycle 3 → single done at cycle 8 with sum=8'h30. No second done follows.
- Back-to-back: start held high through DONE with a=8'h01, b=8'h02 → second done exactly 9 cycles after the first, sum=8'h03.
- Reset mid-operation: assert rst at cycle 4 of an add → outputs 0 immediately. A fresh 8'h03+8'h04 add after release gives sum=8'h07.
- Overflow (macro defined): a=8'h7F, b=8'h01 → sum=8'h80, overflow=1, carry_out=0. a=8'h80, b=8'h80 → sum=8'h00, overflow=1, carry_out=1.
